// File: rtl/fwd_scoreboard_if.sv
// Handshake bundle between the ID-stage controller and the forwarding scoreboard.
// The controller drives the pipeline/issue/query signals; the scoreboard answers.
interface fwd_scoreboard_if #(
    parameter int unsigned CNT_W = 32
);
    logic             Pipe_Adv;
    logic [2:0]       Flush_Mask;
    logic             ID_Issue;
    logic [4:0]       ID_rd;
    logic             ID_WrReg;
    logic [1:0]       ID_ResClass;
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic [1:0]       ID_rsrtRead;
    logic             ID_Stall;
    logic [1:0]       ID_rs_Fwd;
    logic [1:0]       ID_rt_Fwd;
    logic [CNT_W-1:0] Stall_Cnt;

    modport master (
        output Pipe_Adv, Flush_Mask, ID_Issue, ID_rd, ID_WrReg, ID_ResClass,
        output ID_rs, ID_rt, ID_rsrtRead,
        input  ID_Stall, ID_rs_Fwd, ID_rt_Fwd, Stall_Cnt
    );

    modport slave (
        input  Pipe_Adv, Flush_Mask, ID_Issue, ID_rd, ID_WrReg, ID_ResClass,
        input  ID_rs, ID_rt, ID_rsrtRead,
        output ID_Stall, ID_rs_Fwd, ID_rt_Fwd, Stall_Cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// In-flight destination tracker for EXE/MEM/MEM2: answers ID operand queries with a
// youngest-producer forwarding source and a stall request, and counts stall cycles.
module fwd_scoreboard #(
    parameter int unsigned CNT_W = 32
) (
    input logic            clk,
    input logic            rst,
    fwd_scoreboard_if.slave bus
);
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [1:0] cls;
    } rec_t;

    rec_t             r_rec [3];
    rec_t             w_rec_d [3];
    logic [CNT_W-1:0] r_stall_cnt;

    logic [4:0]       w_src [2];
    logic             w_rden [2];
    logic [1:0]       w_fwd [2];
    logic [1:0]       w_stall;

    // A producer in stage s is not ready while s is below its class threshold
    // (ALU 0, MFC0 2, load 3).
    function automatic logic not_ready(input logic [1:0] cls, input int unsigned s);
        case (cls)
            2'b00:   not_ready = 1'b0;
            2'b01:   not_ready = (s < 2);
            default: not_ready = 1'b1;
        endcase
    endfunction

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            w_rec_d[s] = r_rec[s];
        end
        if (bus.Pipe_Adv) begin
            w_rec_d[2]     = r_rec[1];
            w_rec_d[1]     = r_rec[0];
            w_rec_d[0].v   = bus.ID_Issue & bus.ID_WrReg & (bus.ID_rd != 5'd0);
            w_rec_d[0].rd  = bus.ID_rd;
            w_rec_d[0].cls = bus.ID_ResClass;
        end
        for (int s = 0; s < 3; s++) begin
            if (bus.Flush_Mask[s]) begin
                w_rec_d[s].v = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                r_rec[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 3; s++) begin
                r_rec[s] <= w_rec_d[s];
            end
        end
    end

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        w_src[0]  = bus.ID_rs;
        w_src[1]  = bus.ID_rt;
        w_rden[0] = bus.ID_rsrtRead[1];
        w_rden[1] = bus.ID_rsrtRead[0];
        w_stall   = '0;
        for (int op = 0; op < 2; op++) begin
            w_fwd[op] = 2'b00;
            for (int s = 2; s >= 0; s--) begin
                if (w_rden[op] && (w_src[op] != 5'd0) && r_rec[s].v
                        && (r_rec[s].rd == w_src[op])) begin
                    w_fwd[op]   = 2'(s + 1);
                    w_stall[op] = not_ready(r_rec[s].cls, int'(s));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (bus.ID_Stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.ID_Stall  = |w_stall;
    assign bus.ID_rs_Fwd = w_fwd[0];
    assign bus.ID_rt_Fwd = w_fwd[1];
    assign bus.Stall_Cnt = r_stall_cnt;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a 32-bit and a 4-bit counter build share stimulus
// and are checked every cycle against a stage-list model plus hand-computed literals.
module tb_fwd_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adv = 1'b0;
    logic [2:0] flush = '0;
    logic       issue = 1'b0;
    logic [4:0] rd = '0;
    logic       wr = 1'b0;
    logic [1:0] cls = '0;
    logic [4:0] rs = '0;
    logic [4:0] rt = '0;
    logic [1:0] rdbits = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.CNT_W(32)) bus32 ();
    fwd_scoreboard_if #(.CNT_W(4))  bus4 ();

    assign bus32.Pipe_Adv = adv;     assign bus4.Pipe_Adv = adv;
    assign bus32.Flush_Mask = flush; assign bus4.Flush_Mask = flush;
    assign bus32.ID_Issue = issue;   assign bus4.ID_Issue = issue;
    assign bus32.ID_rd = rd;         assign bus4.ID_rd = rd;
    assign bus32.ID_WrReg = wr;      assign bus4.ID_WrReg = wr;
    assign bus32.ID_ResClass = cls;  assign bus4.ID_ResClass = cls;
    assign bus32.ID_rs = rs;         assign bus4.ID_rs = rs;
    assign bus32.ID_rt = rt;         assign bus4.ID_rt = rt;
    assign bus32.ID_rsrtRead = rdbits; assign bus4.ID_rsrtRead = rdbits;

    fwd_scoreboard #(.CNT_W(32)) u_dut (.clk(clk), .rst(rst), .bus(bus32));
    fwd_scoreboard #(.CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Model: list of in-flight producers, index 0 = youngest (EXE).
    bit         mv [3];
    logic [4:0] mrd [3];
    logic [1:0] mcls [3];
    longint     mcnt32 = 0;
    longint     mcnt4 = 0;
    bit         started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_query(input logic [4:0] x, input bit en,
                                        output logic [1:0] fwd, output bit stall);
        int youngest = -1;
        int ready_at;
        fwd = 2'b00;
        stall = 1'b0;
        if (en && x != 5'd0) begin
            for (int s = 0; s < 3; s++) begin
                if (mv[s] && mrd[s] == x) begin
                    youngest = s;
                    break;
                end
            end
        end
        if (youngest >= 0) begin
            fwd = 2'(youngest + 1);
            ready_at = (mcls[youngest] == 2'b00) ? 0 : (mcls[youngest] == 2'b01) ? 2 : 3;
            stall = youngest < ready_at;
        end
    endfunction

    function automatic bit model_stall();
        logic [1:0] f;
        bit s0, s1;
        model_query(rs, rdbits[1], f, s0);
        model_query(rt, rdbits[0], f, s1);
        return s0 | s1;
    endfunction

    always @(posedge clk) begin
        bit         nv [3];
        logic [4:0] nrd [3];
        logic [1:0] ncls [3];
        bit         st;
        st = model_stall();
        if (rst) begin
            for (int s = 0; s < 3; s++) mv[s] = 1'b0;
            mcnt32 = 0;
            mcnt4 = 0;
            started = 1'b1;
        end else begin
            for (int s = 0; s < 3; s++) begin
                nv[s] = mv[s]; nrd[s] = mrd[s]; ncls[s] = mcls[s];
            end
            if (adv) begin
                for (int s = 2; s > 0; s--) begin
                    nv[s] = mv[s-1]; nrd[s] = mrd[s-1]; ncls[s] = mcls[s-1];
                end
                nv[0] = issue && wr && rd != 5'd0; nrd[0] = rd; ncls[0] = cls;
            end
            for (int s = 0; s < 3; s++) begin
                if (flush[s]) nv[s] = 1'b0;
                mv[s] = nv[s]; mrd[s] = nrd[s]; mcls[s] = ncls[s];
            end
            if (st && mcnt32 < 64'hFFFF_FFFF) mcnt32++;
            if (st && mcnt4 < 15) mcnt4++;
        end
    end

    always @(negedge clk) begin
        logic [1:0] frs, frt;
        bit         srs, srt;
        if (started) begin
            model_query(rs, rdbits[1], frs, srs);
            model_query(rt, rdbits[0], frt, srt);
            chk("cyc.stall", bus32.ID_Stall, srs | srt);
            chk("cyc.rs_fwd", bus32.ID_rs_Fwd, frs);
            chk("cyc.rt_fwd", bus32.ID_rt_Fwd, frt);
            chk("cyc.cnt32", bus32.Stall_Cnt, mcnt32);
            chk("cyc4.stall", bus4.ID_Stall, srs | srt);
            chk("cyc4.rs_fwd", bus4.ID_rs_Fwd, frs);
            chk("cyc4.cnt4", bus4.Stall_Cnt, mcnt4);
        end
    end

    task automatic tick(input bit a, input logic [2:0] f, input bit iss,
                        input logic [4:0] d, input bit w, input logic [1:0] c);
        adv = a; flush = f; issue = iss; rd = d; wr = w; cls = c;
        @(posedge clk);
        #1;
        adv = 1'b0; flush = '0; issue = 1'b0; rd = '0; wr = 1'b0; cls = '0;
    endtask

    task automatic query(input logic [4:0] s, input logic [4:0] t, input logic [1:0] r);
        rs = s; rt = t; rdbits = r;
        #1;
    endtask

    task automatic expect_out(input string name, input bit st, input logic [1:0] fs,
                              input logic [1:0] ft);
        chk({name, ".stall"}, bus32.ID_Stall, st);
        chk({name, ".rs_fwd"}, bus32.ID_rs_Fwd, fs);
        chk({name, ".rt_fwd"}, bus32.ID_rt_Fwd, ft);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick(0, 3'b000, 0, 0, 0, 0);
        tick(0, 3'b000, 0, 0, 0, 0);
        rst = 1'b0;
        query(0, 0, 2'b00);
        expect_out("reset", 0, 2'b00, 2'b00);
        chk("reset.cnt", bus32.Stall_Cnt, 0);

        // Load r5 then a reader of r5
        tick(1, 3'b000, 1, 5'd5, 1, 2'b10);
        query(5'd5, 0, 2'b10);
        expect_out("load_exe", 1, 2'b01, 2'b00);
        tick(1, 3'b000, 0, 0, 0, 0);
        expect_out("load_mem", 1, 2'b10, 2'b00);
        tick(1, 3'b000, 0, 0, 0, 0);
        expect_out("load_mem2", 1, 2'b11, 2'b00);
        tick(1, 3'b000, 0, 0, 0, 0);
        expect_out("load_gone", 0, 2'b00, 2'b00);
        chk("load.cnt", bus32.Stall_Cnt, 3);

        // ALU r3 forwarding walk on rt
        query(0, 0, 2'b00);
        tick(1, 3'b000, 1, 5'd3, 1, 2'b00);
        query(0, 5'd3, 2'b01);
        expect_out("alu_exe", 0, 2'b00, 2'b01);
        tick(1, 3'b000, 0, 0, 0, 0);
        expect_out("alu_mem", 0, 2'b00, 2'b10);
        tick(1, 3'b000, 0, 0, 0, 0);
        expect_out("alu_mem2", 0, 2'b00, 2'b11);
        tick(1, 3'b000, 0, 0, 0, 0);
        expect_out("alu_gone", 0, 2'b00, 2'b00);

        // MFC0 r8
        query(0, 0, 2'b00);
        tick(1, 3'b000, 1, 5'd8, 1, 2'b01);
        query(5'd8, 0, 2'b10);
        expect_out("mfc0_exe", 1, 2'b01, 2'b00);
        tick(1, 3'b000, 0, 0, 0, 0);
        expect_out("mfc0_mem", 1, 2'b10, 2'b00);
        tick(1, 3'b000, 0, 0, 0, 0);
        expect_out("mfc0_mem2", 0, 2'b11, 2'b00);
        chk("mfc0.cnt", bus32.Stall_Cnt, 5);
        tick(1, 3'b000, 0, 0, 0, 0);

        // Load r4 in MEM2 hidden by ALU r4 in EXE, then flush EXE
        query(0, 0, 2'b00);
        tick(1, 3'b000, 1, 5'd4, 1, 2'b10);
        tick(1, 3'b000, 0, 0, 0, 0);
        tick(1, 3'b000, 1, 5'd4, 1, 2'b00);
        query(5'd4, 0, 2'b10);
        expect_out("hide", 0, 2'b01, 2'b00);
        tick(0, 3'b001, 0, 0, 0, 0);
        expect_out("unhide", 1, 2'b11, 2'b00);
        query(0, 0, 2'b00);
        repeat (3) tick(1, 3'b000, 0, 0, 0, 0);

        // r0 writes never tracked; unread operands never match
        tick(1, 3'b000, 1, 5'd0, 1, 2'b10);
        query(0, 0, 2'b11);
        expect_out("r0", 0, 2'b00, 2'b00);
        query(0, 0, 2'b00);
        tick(1, 3'b000, 1, 5'd7, 1, 2'b10);
        query(5'd7, 5'd7, 2'b00);
        expect_out("noread", 0, 2'b00, 2'b00);
        query(5'd7, 5'd7, 2'b11);
        expect_out("both", 1, 2'b01, 2'b01);

        // Held stall saturates the 4-bit counter
        repeat (20) tick(0, 3'b000, 0, 0, 0, 0);
        chk("sat.cnt4", bus4.Stall_Cnt, 15);
        chk("sat.cnt32", bus32.Stall_Cnt, 25);

        // Reset mid-stream with advance active
        rst = 1'b1;
        tick(1, 3'b000, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        expect_out("rst_mid", 0, 2'b00, 2'b00);
        chk("rst_mid.cnt32", bus32.Stall_Cnt, 0);
        chk("rst_mid.cnt4", bus4.Stall_Cnt, 0);
        repeat (2) tick(0, 3'b000, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Producer-side in-flight destination tracker for the ID stage.
- Keeps a shadow record (valid, dest reg, result class) for each instruction in EXE, MEM and MEM2, shifted in lockstep with the pipeline.
- Answers ID operand queries with a stall request and a per-operand forwarding source, always taking the youngest matching producer.
- Also keeps a saturating count of stall cycles for performance monitoring.

Parameters:
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- Pipe_Adv  input  1  EXE/MEM/MEM2 registers advance this cycle
- Flush_Mask  input  3  [0]=EXE, [1]=MEM, [2]=MEM2; invalidate that stage's record
- ID_Issue  input  1  instruction in ID enters EXE on this advance
- ID_rd  input  5  destination register of the issuing instruction
- ID_WrReg  input  1  issuing instruction writes a GPR
- ID_ResClass  input  2  00 ALU (result at end of EXE), 01 MFC0 (end of MEM), 10 load (end of MEM2), 11 treated as 10
- ID_rs  input  5  source register rs of the instruction in ID
- ID_rt  input  5  source register rt of the instruction in ID
- ID_rsrtRead  input  2  [1] rs read, [0] rt read
- ID_Stall  output  1  ID must hold and insert a bubble into EXE
- ID_rs_Fwd  output  2  rs source: 00 regfile, 01 EXE, 10 MEM, 11 MEM2
- ID_rt_Fwd  output  2  rt source, same encoding
- Stall_Cnt  output  CNT_W  saturating count of cycles with ID_Stall=1

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- State: three records R[s] for s = 0 (EXE), 1 (MEM), 2 (MEM2). Each record is {v, rd[4:0], cls[1:0]}.
- The regfile is write-first, so a producer leaving MEM2 needs no tracking.
- Reset: all v=0 and Stall_Cnt=0. Outputs then read ID_Stall=0 and both Fwd=00.

Sequential update, in priority order:
1. Flush: for each stage with Flush_Mask[s]=1, next v of R[s] is 0. Flush overrides both advance and issue for that stage.
2. Advance (Pipe_Adv=1):
   - R[2] takes R[1].
   - R[1] takes R[0].
   - R[0] takes {ID_Issue & ID_WrReg & (ID_rd!=0), ID_rd, ID_ResClass}.
   - The old R[2] retires.
   - A flush bit on a destination stage also kills the record shifting into it.
3. No advance (Pipe_Adv=0): records hold. ID_Issue is ignored.

Query logic (combinational, from current records):
- match(s,x) = R[s].v & (R[s].rd == x).
- Fwd for operand x: if its read bit is 0, or x==0, Fwd=00.
  - Otherwise the first s in order 0, 1, 2 with match gives Fwd = s+1.
  - No match gives Fwd=00.
- Stall threshold per class: ALU=0, MFC0=2, load/11=3. A producer in stage s is "not ready" when s < threshold.
- ID_Stall=1 when, for rs or rt (read bit set), the youngest matching record is not ready.
- Older matches hidden by a younger match never cause a stall.

Stall counter:
- Stall_Cnt increments on every cycle with ID_Stall=1.
- It saturates at all-ones and is cleared only by rst.

Boundaries:
- The controller must drive ID_Issue=0 whenever ID_Stall=1.
- A record with v=0 never matches, whatever its rd.
- Same reg in several stages: the youngest wins, both for Fwd and for the stall decision.
- rst mid-stream clears all records on the next edge, even if Flush_Mask or Pipe_Adv is active.

Test Plan:
- Load r5 issued, then add using r5 in ID:
  - load in EXE: ID_Stall=1.
  - after 1 advance (MEM): ID_Stall=1.
  - after 2 advances (MEM2): ID_Stall=1, rs_Fwd=11.
  - after 3 advances: ID_Stall=0, Fwd=00, Stall_Cnt=3.
- ALU writes r3, next instr reads rt=r3: ID_Stall=0, rt_Fwd=01. After 1 advance: rt_Fwd=10, then 11, then 00.
- MFC0 to r8, reader of r8: stall with r8 in EXE and in MEM; no stall with r8 in MEM2, rs_Fwd=11.
- Load r4 in MEM2, ALU r4 in EXE, reader of r4: ID_Stall=0, Fwd=01. Then Flush_Mask=001 with Pipe_Adv=0: ID_Stall=1, Fwd=11.
- Write to r0, and a query with rsrtRead=00 against a matching reg: Fwd=00 and ID_Stall=0 in both cases.
- Stall held with a CNT_W=4 build, 20 cycles: Stall_Cnt=15. Assert rst with Pipe_Adv=1 and records valid: next cycle all outputs are at reset values.
